// File: rtl/ram_write_arbiter.sv
// ============================================================================
// ram_write_arbiter: round-robin burst arbiter for the image RAM write port.
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_write_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] base0,
  input  logic [LEN_W-1:0]  len0,
  input  logic [DATA_W-1:0] data0,
  input  logic              valid0,
  output logic              ready0,
  output logic              done0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] base1,
  input  logic [LEN_W-1:0]  len1,
  input  logic [DATA_W-1:0] data1,
  input  logic              valid1,
  output logic              ready1,
  output logic              done1,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                last;
  logic [ADDR_W-1:0]   base_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    offset;
  logic                pick;
  logic [LEN_W-1:0]    len_pick;
  logic                req_g;
  logic                valid_g;
  logic [DATA_W-1:0]   data_g;
  logic                any_req;
  logic                accept;
  logic                last_word;

  // On a tie the requester that was not served last wins.
  assign pick      = (req0 & req1) ? ~last : req1;
  assign any_req   = req0 | req1;
  assign len_pick  = pick ? len1 : len0;
  assign req_g     = grant ? req1 : req0;
  assign valid_g   = grant ? valid1 : valid0;
  assign data_g    = grant ? data1 : data0;
  // A dropped request aborts the burst, so that beat is never written.
  assign accept    = (state == WRITE) & req_g & valid_g;
  assign last_word = (offset + LEN_W'(1)) == len_q;

  assign ready0 = (state == WRITE) & ~grant;
  assign ready1 = (state == WRITE) & grant;
  assign done0  = (state == FINISH) & ~grant;
  assign done1  = (state == FINISH) & grant;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = (len_pick == '0) ? FINISH : WRITE;
      end
      WRITE: begin
        if (!req_g)                     state_nxt = IDLE;
        else if (valid_g && last_word)  state_nxt = FINISH;
      end
      FINISH: begin
        if (!req_g) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant     <= 1'b0;
      last      <= 1'b1;
      base_q    <= '0;
      len_q     <= '0;
      offset    <= '0;
      wren      <= 1'b0;
      data      <= '0;
      wraddress <= '0;
    end else begin
      wren <= accept;
      if (state == IDLE && any_req) begin
        grant  <= pick;
        base_q <= pick ? base1 : base0;
        len_q  <= len_pick;
        offset <= '0;
      end
      if (accept) begin
        wraddress <= base_q + ADDR_W'(offset);
        data      <= data_g;
        offset    <= offset + LEN_W'(1);
      end
      if (state != IDLE && state_nxt == IDLE) last <= grant;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_write_arbiter.sv
// ============================================================================
// tb_ram_write_arbiter: directed self-checking bench for ram_write_arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ram_write_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0, req1, valid0, valid1;
  logic [11:0] base0, base1;
  logic [4:0]  len0, len1;
  logic [31:0] data0, data1;
  logic        ready0, ready1, done0, done1;
  logic [11:0] wraddress;
  logic [31:0] data;
  logic        wren, busy, grant;

  int checks = 0;
  int errors = 0;

  ram_write_arbiter #(.ADDR_W(12), .DATA_W(32), .LEN_W(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .base0(base0), .len0(len0), .data0(data0), .valid0(valid0),
    .ready0(ready0), .done0(done0),
    .req1(req1), .base1(base1), .len1(len1), .data1(data1), .valid1(valid1),
    .ready1(ready1), .done1(done1),
    .wraddress(wraddress), .data(data), .wren(wren), .busy(busy), .grant(grant)
  );

  always #5 clock = ~clock;

  // Advance one rising edge; observe 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; valid0 = 0; valid1 = 0;
    base0 = '0; base1 = '0; len0 = '0; len1 = '0; data0 = '0; data1 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  // ctl = {busy, grant, ready0, ready1, done0, done1, wren}
  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, grant, ready0, ready1, done0, done1, wren, wraddress, data} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b grant=%b rdy=%b%b done=%b%b wren=%b addr=%h data=%h want all 0",
               busy, grant, ready0, ready1, done0, done1, wren, wraddress, data);
    end
  endtask

  task automatic test_single_burst();
    logic [31:0] words [3];
    words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
    do_reset();
    req0 = 1; base0 = 12'h010; len0 = 5'd3; valid0 = 1; data0 = words[0];
    step();
    checks++;
    if ({busy, grant, ready0, ready1, wren} !== 5'b10100) begin
      errors++;
      $display("FAIL single_grant got busy/grant/rdy0/rdy1/wren=%b want 10100",
               {busy, grant, ready0, ready1, wren});
    end
    for (int k = 0; k < 3; k++) begin
      if (k < 2) data0 = words[k];
      step();
      if (k < 2) data0 = words[k + 1];
      checks++;
      if ({wren, wraddress, data, done0} !== {1'b1, 12'h010 + 12'(k), words[k], (k == 2)}) begin
        errors++;
        $display("FAIL single_write%0d got wren=%b addr=%h data=%h done0=%b want 1 %h %h %b",
                 k, wren, wraddress, data, done0, 12'h010 + 12'(k), words[k], (k == 2));
      end
    end
    valid0 = 0;
    step();
    checks++;
    if ({wren, done0, busy} !== 3'b011) begin
      errors++;
      $display("FAIL single_hold got wren/done0/busy=%b want 011", {wren, done0, busy});
    end
    req0 = 0;
    step();
    checks++;
    if ({wren, done0, busy} !== 3'b000) begin
      errors++;
      $display("FAIL single_release got wren/done0/busy=%b want 000", {wren, done0, busy});
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req0 = 1; req1 = 1; len0 = 5'd2; len1 = 5'd2;
    base0 = 12'h100; base1 = 12'h200; valid0 = 1; valid1 = 1;
    data0 = 32'h11; data1 = 32'h22;
    step();
    checks++;
    if ({busy, grant, ready0, ready1} !== 4'b1010) begin
      errors++;
      $display("FAIL tie_grant0 got busy/grant/rdy0/rdy1=%b want 1010", {busy, grant, ready0, ready1});
    end
    step();
    step();
    checks++;
    if ({wren, wraddress, data, done0, done1} !== {1'b1, 12'h101, 32'h11, 2'b10}) begin
      errors++;
      $display("FAIL tie_req0_last got wren=%b addr=%h data=%h done=%b%b want 1 101 00000011 10",
               wren, wraddress, data, done0, done1);
    end
    req0 = 0; valid0 = 0;
    step();
    step();
    checks++;
    if ({busy, grant, ready1} !== 3'b111) begin
      errors++;
      $display("FAIL tie_grant1 got busy/grant/rdy1=%b want 111", {busy, grant, ready1});
    end
    step();
    checks++;
    if ({wren, wraddress, data} !== {1'b1, 12'h200, 32'h22}) begin
      errors++;
      $display("FAIL tie_req1_first got wren=%b addr=%h data=%h want 1 200 00000022", wren, wraddress, data);
    end
    step();
    checks++;
    if ({wraddress, done1, done0} !== {12'h201, 2'b10}) begin
      errors++;
      $display("FAIL tie_req1_last got addr=%h done1=%b done0=%b want 201 1 0", wraddress, done1, done0);
    end
    req1 = 0; valid1 = 0;
    step();
    req0 = 1; req1 = 1;
    step();
    checks++;
    if ({busy, grant} !== 2'b10) begin
      errors++;
      $display("FAIL tie_second_grant got busy/grant=%b want 10", {busy, grant});
    end
  endtask

  task automatic test_backpressure_wrap();
    logic [5:0]  pat;
    logic [11:0] exp_addr;
    int          acc;
    pat = 6'b101101;  // beat 0 first, read from bit 5 down
    do_reset();
    req1 = 1; base1 = 12'hFFE; len1 = 5'd4;
    step();
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      valid1 = pat[5 - k];
      data1  = 32'h100 + 32'(k);
      step();
      if (pat[5 - k]) begin
        exp_addr = 12'hFFE + 12'(acc);
        checks++;
        if ({wren, wraddress, data} !== {1'b1, exp_addr, 32'h100 + 32'(k)}) begin
          errors++;
          $display("FAIL bp_beat%0d got wren=%b addr=%h data=%h want 1 %h %h",
                   k, wren, wraddress, data, exp_addr, 32'h100 + 32'(k));
        end
        acc++;
      end else begin
        checks++;
        if (wren !== 1'b0) begin
          errors++;
          $display("FAIL bp_gap%0d got wren=%b want 0", k, wren);
        end
      end
    end
    checks++;
    if ({done1, done0, wraddress} !== {2'b10, 12'h001}) begin
      errors++;
      $display("FAIL bp_done got done1=%b done0=%b addr=%h want 1 0 001", done1, done0, wraddress);
    end
    valid1 = 0; req1 = 0;
    step();
  endtask

  task automatic test_zero_length();
    do_reset();
    req0 = 1; base0 = 12'h055; len0 = 5'd0; valid0 = 1; data0 = 32'hDEAD;
    step();
    checks++;
    if ({busy, grant, ready0, done0, wren} !== 5'b10010) begin
      errors++;
      $display("FAIL zero_grant got busy/grant/rdy0/done0/wren=%b want 10010", {busy, grant, ready0, done0, wren});
    end
    step();
    checks++;
    if ({done0, wren} !== 2'b10) begin
      errors++;
      $display("FAIL zero_hold got done0/wren=%b want 10", {done0, wren});
    end
    req0 = 0;
    step();
    checks++;
    if ({done0, busy, wren} !== 3'b000) begin
      errors++;
      $display("FAIL zero_release got done0/busy/wren=%b want 000", {done0, busy, wren});
    end
  endtask

  task automatic test_abort();
    do_reset();
    req0 = 1; base0 = 12'h040; len0 = 5'd5; valid0 = 1; data0 = 32'h5;
    req1 = 1; base1 = 12'h300; len1 = 5'd1; valid1 = 1; data1 = 32'h77;
    step();
    step();
    step();
    checks++;
    if ({wren, wraddress, grant} !== {1'b1, 12'h041, 1'b0}) begin
      errors++;
      $display("FAIL abort_second got wren=%b addr=%h grant=%b want 1 041 0", wren, wraddress, grant);
    end
    req0 = 0; valid0 = 0;
    step();
    checks++;
    if ({wren, busy, done0} !== 3'b000) begin
      errors++;
      $display("FAIL abort_stop got wren/busy/done0=%b want 000", {wren, busy, done0});
    end
    step();
    checks++;
    if ({busy, grant, ready1} !== 3'b111) begin
      errors++;
      $display("FAIL abort_next_grant got busy/grant/rdy1=%b want 111", {busy, grant, ready1});
    end
    step();
    checks++;
    if ({wren, wraddress, data, done1} !== {1'b1, 12'h300, 32'h77, 1'b1}) begin
      errors++;
      $display("FAIL abort_req1 got wren=%b addr=%h data=%h done1=%b want 1 300 00000077 1",
               wren, wraddress, data, done1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req0 = 1; base0 = 12'h080; len0 = 5'd5; valid0 = 1; data0 = 32'h99;
    step();
    step();
    checks++;
    if ({wren, busy, ready0} !== 3'b111) begin
      errors++;
      $display("FAIL areset_pre got wren/busy/rdy0=%b want 111", {wren, busy, ready0});
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({wren, busy, ready0, ready1, done0, done1, grant, wraddress} !== '0) begin
      errors++;
      $display("FAIL areset_now got wren=%b busy=%b rdy=%b%b done=%b%b grant=%b addr=%h want all 0",
               wren, busy, ready0, ready1, done0, done1, grant, wraddress);
    end
    #2 reset_n = 1'b1;
    req1 = 1; len1 = 5'd1;
    step();
    checks++;
    if ({busy, grant, wren} !== 3'b100) begin
      errors++;
      $display("FAIL areset_tie got busy/grant/wren=%b want 100", {busy, grant, wren});
    end
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure_wrap();
    test_zero_length();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
